matrix_key_scan: RTL and testbench

Keypad input scanner for the vending-machine front panel. It is the input-side counterpart of the 7-segment output driver. It drives a 4x4 matrix keypad one row at a time with active-low row select and reads the active-low columns. It debounces presses and releases, and emits one 4-bit key code with a single-cycle valid pulse per press. The code and valid outputs go to the coin/selection control FSM.

---
 rtl/matrix_key_scan_pkg.sv | 32 +++
 rtl/matrix_key_scan_sync.sv | 23 ++
 rtl/matrix_key_scan.sv | 145 ++++++++++++++
 tb/tb_matrix_key_scan.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/matrix_key_scan_pkg.sv
// Shared types and constants for the front-panel keypad scanner.
package matrix_key_scan_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2,
    RELEASE  = 2'd3
  } key_state_t;

  localparam int unsigned KEY_ROWS = 4;
  localparam int unsigned KEY_COLS = 4;
  localparam logic [3:0]  ROW_IDLE = 4'hF;

  // Panel mapping of the two control keys on the bottom row.
  localparam logic [3:0] KEY_CONFIRM = 4'hE;
  localparam logic [3:0] KEY_CANCEL  = 4'hF;

  // Lowest-index low column wins when several columns read low.
  function automatic logic [1:0] low_col_idx(input logic [3:0] col);
    logic [1:0] idx;
    casez (col)
      4'b???0: idx = 2'd0;
      4'b??01: idx = 2'd1;
      4'b?011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/matrix_key_scan_sync.sv
// Two-flop synchronizer; resets to all-ones so idle pulled-up inputs read as released.
module key_sync #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/matrix_key_scan.sv
// 4x4 keypad scanner: one-cold row drive, debounced press/release, one valid pulse per press.
module matrix_key_scan
  import matrix_key_scan_pkg::*;
#(
  parameter int unsigned ROW_DWELL    = 4,
  parameter int unsigned DEBOUNCE_CNT = 20
) (
  input  logic                key_clk,
  input  logic                key_rst_n,
  input  logic [KEY_COLS-1:0] key_col,
  output logic [KEY_ROWS-1:0] key_row,
  output logic [3:0]          key_code,
  output logic                key_valid,
  output logic                key_down
);

  localparam int unsigned DWELL_W = (ROW_DWELL > 1) ? $clog2(ROW_DWELL) : 1;
  localparam int unsigned DEB_W   = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(ROW_DWELL - 1);
  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CNT - 1);
  // The HOLD cycle that first sees all-high counts as the first release sample.
  localparam logic [DEB_W-1:0]   REL_LAST   = DEB_W'(DEBOUNCE_CNT - 2);

  key_state_t          state, state_nxt;
  logic [1:0]          row_idx, row_idx_nxt;
  logic [1:0]          col_idx, col_idx_nxt;
  logic [3:0]          pat, pat_nxt;
  logic [3:0]          col_s;
  logic [DWELL_W-1:0]  dwell_cnt, dwell_nxt;
  logic [DEB_W-1:0]    deb_cnt, deb_nxt;
  logic                accept, release_done;
  logic [KEY_ROWS-1:0] row_nxt;
  logic [3:0]          code_nxt;
  logic                valid_nxt, down_nxt;

  key_sync #(.WIDTH(KEY_COLS)) u_col_sync (
    .clk   (key_clk),
    .rst_n (key_rst_n),
    .d     (key_col),
    .q     (col_s)
  );

  always_ff @(posedge key_clk or negedge key_rst_n) begin
    if (!key_rst_n) begin
      state     <= SCAN;
      row_idx   <= '0;
      col_idx   <= '0;
      pat       <= ROW_IDLE;
      dwell_cnt <= '0;
      deb_cnt   <= '0;
      key_row   <= 4'b1110;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      state     <= state_nxt;
      row_idx   <= row_idx_nxt;
      col_idx   <= col_idx_nxt;
      pat       <= pat_nxt;
      dwell_cnt <= dwell_nxt;
      deb_cnt   <= deb_nxt;
      key_row   <= row_nxt;
      key_code  <= code_nxt;
      key_valid <= valid_nxt;
      key_down  <= down_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    row_idx_nxt  = row_idx;
    col_idx_nxt  = col_idx;
    pat_nxt      = pat;
    dwell_nxt    = dwell_cnt;
    deb_nxt      = deb_cnt;
    accept       = 1'b0;
    release_done = 1'b0;
    case (state)
      SCAN: begin
        if (dwell_cnt == DWELL_LAST) begin
          dwell_nxt = '0;
          if (col_s == ROW_IDLE) begin
            row_idx_nxt = row_idx + 2'd1;
          end else begin
            pat_nxt     = col_s;
            col_idx_nxt = low_col_idx(col_s);
            deb_nxt     = '0;
            state_nxt   = DEBOUNCE;
          end
        end else begin
          dwell_nxt = dwell_cnt + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (col_s == ROW_IDLE) begin
          state_nxt   = SCAN;
          row_idx_nxt = row_idx + 2'd1;
          dwell_nxt   = '0;
        end else if (col_s != pat) begin
          pat_nxt     = col_s;
          col_idx_nxt = low_col_idx(col_s);
          deb_nxt     = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt = HOLD;
          accept    = 1'b1;
        end else begin
          deb_nxt = deb_cnt + 1'b1;
        end
      end
      HOLD: begin
        if (col_s == ROW_IDLE) begin
          state_nxt = RELEASE;
          deb_nxt   = '0;
        end
      end
      RELEASE: begin
        if (col_s != ROW_IDLE) begin
          state_nxt = HOLD;
        end else if (deb_cnt == REL_LAST) begin
          state_nxt    = SCAN;
          release_done = 1'b1;
          row_idx_nxt  = row_idx + 2'd1;
          dwell_nxt    = '0;
        end else begin
          deb_nxt = deb_cnt + 1'b1;
        end
      end
      default: state_nxt = SCAN;
    endcase
  end

  // Row drive follows the next row index so key_row and row_idx change on the same edge.
  always_comb begin
    row_nxt   = ~(KEY_ROWS'(1) << row_idx_nxt);
    valid_nxt = accept;
    code_nxt  = accept ? {row_idx, col_idx} : key_code;
    down_nxt  = key_down;
    if (accept) begin
      down_nxt = 1'b1;
    end else if (release_done) begin
      down_nxt = 1'b0;
    end
  end

endmodule

// File: tb/tb_matrix_key_scan.sv
// Directed bench for matrix_key_scan with a behavioural 4x4 keypad on the row/column lines.
module tb_matrix_key_scan;

  logic        key_clk = 1'b0;
  logic        key_rst_n = 1'b0;
  logic [3:0]  key_col;
  logic [3:0]  key_row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic [15:0] pressed = '0;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;

  always #5 key_clk = ~key_clk;

  matrix_key_scan #(.ROW_DWELL(4), .DEBOUNCE_CNT(20)) dut (
    .key_clk   (key_clk),
    .key_rst_n (key_rst_n),
    .key_col   (key_col),
    .key_row   (key_row),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  // A pressed key pulls its column low while its row is driven low.
  always_comb begin
    key_col = '1;
    for (int unsigned r = 0; r < 4; r++)
      for (int unsigned c = 0; c < 4; c++)
        if (pressed[r*4+c] && !key_row[r]) key_col[c] = 1'b0;
  end

  always @(posedge key_clk) if (key_valid) valid_cnt <= valid_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge key_clk);
      #1;
    end
  endtask

  task automatic wait_valid(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(posedge key_clk);
      #1;
      if (key_valid) seen = 1'b1;
    end
  endtask

  // Returns the index of the posedge after which key_down reads low, 0 if it never did.
  task automatic wait_down_low(input int limit, output int n);
    n = 0;
    for (int i = 1; i <= limit && n == 0; i++) begin
      @(posedge key_clk);
      #1;
      if (!key_down) n = i;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_row"},   32'(key_row),   32'h0000_000E);
    check_eq({tag, "_code"},  32'(key_code),  32'h0);
    check_eq({tag, "_valid"}, 32'(key_valid), 32'h0);
    check_eq({tag, "_down"},  32'(key_down),  32'h0);
  endtask

  initial begin
    bit seen;
    int n;
    int v0;

    // Reset with no keys, then free-running row scan.
    repeat (2) @(negedge key_clk);
    check_reset_outputs("reset");
    @(negedge key_clk) key_rst_n = 1'b1;
    tick(2);  check_eq("scan_row0", 32'(key_row), 32'hE);
    tick(4);  check_eq("scan_row1", 32'(key_row), 32'hD);
    tick(4);  check_eq("scan_row2", 32'(key_row), 32'hB);
    tick(4);  check_eq("scan_row3", 32'(key_row), 32'h7);
    tick(4);  check_eq("scan_wrap", 32'(key_row), 32'hE);
    check_eq("scan_no_valid", 32'(valid_cnt), 32'd0);
    check_eq("scan_no_down",  32'(key_down),  32'd0);

    // 10-cycle glitch on key 0 right after reset: rejected, scan moves to row 1.
    @(negedge key_clk) key_rst_n = 1'b0;
    @(negedge key_clk) begin key_rst_n = 1'b1; pressed[0] = 1'b1; end
    repeat (10) @(negedge key_clk);
    pressed[0] = 1'b0;
    tick(5);
    check_eq("glitch_next_row", 32'(key_row),   32'hD);
    check_eq("glitch_no_valid", 32'(valid_cnt), 32'd0);
    check_eq("glitch_no_down",  32'(key_down),  32'd0);

    // Clean press of row 2 col 1, held ~100 cycles.
    @(negedge key_clk) pressed[9] = 1'b1;
    v0 = valid_cnt;
    wait_valid(200, seen);
    check_eq("k9_seen",  32'(seen),     32'd1);
    check_eq("k9_code",  32'(key_code), 32'h9);
    check_eq("k9_down",  32'(key_down), 32'd1);
    check_eq("k9_row",   32'(key_row),  32'hB);
    tick(1);
    check_eq("k9_pulse_width", 32'(key_valid), 32'd0);
    tick(90);
    check_eq("k9_one_pulse",   32'(valid_cnt - v0), 32'd1);
    check_eq("k9_row_frozen",  32'(key_row),  32'hB);
    check_eq("k9_still_down",  32'(key_down), 32'd1);
    check_eq("k9_code_held",   32'(key_code), 32'h9);
    @(negedge key_clk) pressed[9] = 1'b0;
    wait_down_low(60, n);
    check_eq("k9_release_edges", 32'(n), 32'd22);

    // Bouncing press on row 1 col 3, then stable.
    v0 = valid_cnt;
    for (int i = 0; i < 8; i++) begin
      pressed[7] = (i % 2 == 0);
      repeat (5) @(negedge key_clk);
    end
    check_eq("k7_bounce_no_valid", 32'(valid_cnt - v0), 32'd0);
    pressed[7] = 1'b1;
    wait_valid(200, seen);
    check_eq("k7_seen", 32'(seen),     32'd1);
    check_eq("k7_code", 32'(key_code), 32'h7);
    tick(10);
    @(negedge key_clk) pressed[7] = 1'b0;
    wait_down_low(60, n);
    check_eq("k7_release_edges", 32'(n), 32'd22);
    check_eq("k7_one_pulse", 32'(valid_cnt - v0), 32'd1);

    // Key 5 with three low re-glitches during release.
    v0 = valid_cnt;
    @(negedge key_clk) pressed[5] = 1'b1;
    wait_valid(200, seen);
    check_eq("k5_seen", 32'(seen),     32'd1);
    check_eq("k5_code", 32'(key_code), 32'h5);
    tick(5);
    @(negedge key_clk);
    for (int g = 0; g < 3; g++) begin
      pressed[5] = 1'b0;
      repeat (3) @(negedge key_clk);
      pressed[5] = 1'b1;
      repeat (2) @(negedge key_clk);
      check_eq("k5_glitch_down", 32'(key_down), 32'd1);
    end
    pressed[5] = 1'b0;
    wait_down_low(60, n);
    check_eq("k5_release_edges", 32'(n), 32'd22);
    check_eq("k5_one_pulse", 32'(valid_cnt - v0), 32'd1);

    // Two keys in row 3 (cols 0 and 2), async reset mid-hold, re-detect after reset.
    v0 = valid_cnt;
    @(negedge key_clk) begin pressed[12] = 1'b1; pressed[14] = 1'b1; end
    wait_valid(200, seen);
    check_eq("kc_seen", 32'(seen),     32'd1);
    check_eq("kc_code", 32'(key_code), 32'hC);
    tick(5);
    @(posedge key_clk);
    #2 key_rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge key_clk) key_rst_n = 1'b1;
    wait_valid(200, seen);
    check_eq("kc_redetect_seen", 32'(seen),     32'd1);
    check_eq("kc_redetect_code", 32'(key_code), 32'hC);
    check_eq("kc_redetect_down", 32'(key_down), 32'd1);
    @(negedge key_clk) begin pressed[12] = 1'b0; pressed[14] = 1'b0; end
    wait_down_low(60, n);
    check_eq("kc_release_edges", 32'(n), 32'd22);
    check_eq("kc_two_pulses", 32'(valid_cnt - v0), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
